// File: rtl/m_store_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// m_store_buf : store address check, lane formatting and 2-entry bus FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
module m_store_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [1:0]  M_sel_st,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        Ov,
  input  logic        flush,
  input  logic        bus_ready,
  output logic        AdES,
  output logic        stall,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  output logic        buf_empty
);

  localparam logic [1:0] SEL_SW   = 2'b00;
  localparam logic [1:0] SEL_SH   = 2'b01;
  localparam logic [1:0] SEL_SB   = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  logic        is_store;
  logic        in_dm, in_tc0, in_tc1, in_misc, in_cnt;
  logic        misalign;
  logic        st_ok, push, pop;
  logic [3:0]  fmt_byteen;
  logic [31:0] fmt_wdata;

  logic [1:0]  count_q, count_d;
  logic        wptr_q, rptr_q;
  logic [31:0] addr_q   [2];
  logic [3:0]  byteen_q [2];
  logic [31:0] wdata_q  [2];

  assign is_store = st_valid && (M_sel_st != SEL_NONE);

  assign in_dm   = (addr <= 32'h0000_2FFF);
  assign in_tc0  = (addr >= 32'h0000_7F00) && (addr <= 32'h0000_7F0B);
  assign in_tc1  = (addr >= 32'h0000_7F10) && (addr <= 32'h0000_7F1B);
  assign in_misc = (addr >= 32'h0000_7F20) && (addr <= 32'h0000_7F23);
  // Timer count registers are read-only from the store side
  assign in_cnt  = ((addr >= 32'h0000_7F08) && (addr <= 32'h0000_7F0B)) ||
                   ((addr >= 32'h0000_7F18) && (addr <= 32'h0000_7F1B));

  assign misalign = ((M_sel_st == SEL_SW) && (addr[1:0] != 2'b00)) ||
                    ((M_sel_st == SEL_SH) && addr[0]);

  assign AdES = is_store &&
                (Ov || !(in_dm || in_tc0 || in_tc1 || in_misc) || misalign ||
                 ((M_sel_st != SEL_SW) && (in_tc0 || in_tc1)) || in_cnt);

  assign st_ok = is_store && !AdES && !flush;
  assign pop   = (count_q != 2'd0) && bus_ready;
  assign push  = st_ok && ((count_q != 2'd2) || pop);
  assign stall = st_ok && (count_q == 2'd2) && !pop;

  always_comb begin
    fmt_byteen = 4'b0000;
    fmt_wdata  = 32'h0;
    case (M_sel_st)
      SEL_SW: begin
        fmt_byteen = 4'b1111;
        fmt_wdata  = wdata;
      end
      SEL_SH: begin
        fmt_byteen = addr[1] ? 4'b1100 : 4'b0011;
        fmt_wdata  = {2{wdata[15:0]}};
      end
      SEL_SB: begin
        fmt_byteen = 4'b0001 << addr[1:0];
        fmt_wdata  = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i]   <= 32'h0;
        byteen_q[i] <= 4'b0000;
        wdata_q[i]  <= 32'h0;
      end
    end else begin
      count_q <= count_d;
      if (pop) rptr_q <= ~rptr_q;
      if (push) begin
        addr_q[wptr_q]   <= {addr[31:2], 2'b00};
        byteen_q[wptr_q] <= fmt_byteen;
        wdata_q[wptr_q]  <= fmt_wdata;
        wptr_q           <= ~wptr_q;
      end
    end
  end

  assign bus_valid  = (count_q != 2'd0);
  assign buf_empty  = (count_q == 2'd0);
  assign bus_addr   = bus_valid ? addr_q[rptr_q]   : 32'h0;
  assign bus_byteen = bus_valid ? byteen_q[rptr_q] : 4'b0000;
  assign bus_wdata  = bus_valid ? wdata_q[rptr_q]  : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_m_store_buf.sv
`default_nettype none
// Testbench for m_store_buf: directed scenarios plus random traffic vs. a queue model.
module tb_m_store_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [1:0]  M_sel_st;
  logic [31:0] addr, wdata;
  logic        Ov, flush, bus_ready;
  logic        AdES, stall, bus_valid, buf_empty;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_byteen;

  localparam logic [1:0] SW = 2'b00, SH = 2'b01, SB = 2'b10, NS = 2'b11;

  m_store_buf dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .M_sel_st(M_sel_st),
    .addr(addr), .wdata(wdata), .Ov(Ov), .flush(flush), .bus_ready(bus_ready),
    .AdES(AdES), .stall(stall), .bus_valid(bus_valid), .bus_addr(bus_addr),
    .bus_byteen(bus_byteen), .bus_wdata(bus_wdata), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] issued[$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int access_size(input logic [1:0] sel);
    return (sel == SW) ? 4 : (sel == SH) ? 2 : 1;
  endfunction

  function automatic bit inr(input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  function automatic logic ref_ades(input logic [1:0] sel, input logic [31:0] a, input logic ov);
    int  n;
    bit  timer, legal;
    if (sel == NS) return 1'b0;
    n     = access_size(sel);
    timer = inr(a, 32'h7F00, 32'h7F0B) || inr(a, 32'h7F10, 32'h7F1B);
    legal = inr(a, 32'h0, 32'h2FFF) || timer || inr(a, 32'h7F20, 32'h7F23);
    if (ov || !legal) return 1'b1;
    if ((a % n) != 0) return 1'b1;
    if (n < 4 && timer) return 1'b1;
    if (inr(a, 32'h7F08, 32'h7F0B) || inr(a, 32'h7F18, 32'h7F1B)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ent_t ref_ent(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    int   n, off;
    n    = access_size(sel);
    off  = (int'(a % 4) / n) * n;
    e.a  = a - (a % 4);
    e.be = 4'b0000;
    e.d  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      e.be[i]        = (i >= off) && (i < off + n);
      e.d[8*i +: 8]  = d[8*(i % n) +: 8];
    end
    return e;
  endfunction

  // One clock cycle: drive at negedge, check settled outputs, advance model at posedge.
  task automatic step(input logic v, input logic [1:0] sel, input logic [31:0] a,
                      input logic [31:0] d, input logic ov, input logic fl, input logic rdy);
    logic e_ades, ok, do_pop, do_push, e_stall;
    st_valid = v; M_sel_st = sel; addr = a; wdata = d; Ov = ov; flush = fl; bus_ready = rdy;
    #1;
    e_ades  = v ? ref_ades(sel, a, ov) : 1'b0;
    ok      = v && (sel != NS) && !e_ades && !fl;
    do_pop  = (q.size() != 0) && rdy;
    do_push = ok && (q.size() < 2 || do_pop);
    e_stall = ok && (q.size() == 2) && !do_pop;
    chk("ades", AdES, e_ades);
    chk("stall", stall, e_stall);
    chk("bus_valid", bus_valid, q.size() != 0);
    chk("buf_empty", buf_empty, q.size() == 0);
    if (q.size() != 0) begin
      chk("bus_addr", bus_addr, q[0].a);
      chk("bus_byteen", bus_byteen, q[0].be);
      chk("bus_wdata", bus_wdata, q[0].d);
    end
    if (bus_valid && rdy) issued.push_back(bus_addr);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(ref_ent(sel, a, d));
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, NS, 32'h0, 32'h0, 1'b0, 1'b0, rdy);
  endtask

  task automatic bad_store(input logic [1:0] sel, input logic [31:0] a, input logic ov);
    st_valid = 1'b1; M_sel_st = sel; addr = a; wdata = 32'h1234_5678; Ov = ov; flush = 1'b0;
    #1;
    chk("ades_dir", AdES, 1'b1);
    step(1'b1, sel, a, 32'h1234_5678, ov, 1'b0, 1'b1);
    chk("bad_no_push", buf_empty, 1'b1);
  endtask

  logic [31:0] ra;

  initial begin
    reset = 1'b0; st_valid = 1'b0; M_sel_st = NS; addr = 32'h0; wdata = 32'h0;
    Ov = 1'b0; flush = 1'b0; bus_ready = 1'b0;
    #2;
    chk("rst_valid", bus_valid, 1'b0);
    chk("rst_empty", buf_empty, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_addr", bus_addr, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    idle(1'b1);

    // Byte store to upper lane
    step(1'b1, SB, 32'h0000_1003, 32'h0000_00A5, 1'b0, 1'b0, 1'b1);
    chk("sb_addr", bus_addr, 32'h0000_1000);
    chk("sb_be", bus_byteen, 4'b1000);
    chk("sb_data", bus_wdata, 32'hA5A5_A5A5);
    idle(1'b1);
    chk("sb_drained", buf_empty, 1'b1);

    // Address exceptions
    bad_store(SH, 32'h0000_0001, 1'b0);
    bad_store(SW, 32'h0000_7F08, 1'b0);
    bad_store(SB, 32'h0000_7F04, 1'b0);
    bad_store(SW, 32'h0000_3000, 1'b0);
    bad_store(SW, 32'h0000_0000, 1'b1);

    // Back-pressure, stall and simultaneous push/pop
    issued.delete();
    step(1'b1, SW, 32'h0, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    step(1'b1, SW, 32'h4, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    st_valid = 1'b1; M_sel_st = SW; addr = 32'h8; flush = 1'b0; bus_ready = 1'b0;
    #1;
    chk("bp_stall", stall, 1'b1);
    step(1'b1, SW, 32'h8, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
    step(1'b1, SW, 32'h8, 32'h3333_3333, 1'b0, 1'b0, 1'b1);
    chk("bp_full_after_swap", bus_valid, 1'b1);
    idle(1'b1); idle(1'b1); idle(1'b1);
    chk("bp_count", issued.size(), 3);
    if (issued.size() == 3) begin
      chk("bp_order0", issued[0], 32'h0);
      chk("bp_order1", issued[1], 32'h4);
      chk("bp_order2", issued[2], 32'h8);
    end

    // Flush drops the new store but not the buffered one
    issued.delete();
    step(1'b1, SW, 32'h20, 32'hAAAA_0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, SW, 32'h10, 32'hBBBB_0000, 1'b0, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
    chk("fl_count", issued.size(), 1);
    if (issued.size() != 0) chk("fl_addr", issued[0], 32'h20);

    // Asynchronous reset mid-drain
    step(1'b1, SW, 32'h40, 32'h4040_4040, 1'b0, 1'b0, 1'b0);
    step(1'b1, SW, 32'h44, 32'h4444_4444, 1'b0, 1'b0, 1'b0);
    chk("ar_pending", bus_valid, 1'b1);
    st_valid = 1'b0; M_sel_st = NS;
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", bus_valid, 1'b0);
    chk("ar_empty", buf_empty, 1'b1);
    chk("ar_addr", bus_addr, 32'h0);
    chk("ar_be", bus_byteen, 4'b0000);
    chk("ar_data", bus_wdata, 32'h0);
    q.delete();
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    issued.delete();
    idle(1'b1); idle(1'b1); idle(1'b1);
    chk("ar_none", issued.size(), 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: ra = 32'h0000_0000;
        1: ra = 32'h0000_1000;
        2: ra = 32'h0000_2FFC;
        3: ra = 32'h0000_3000;
        4: ra = 32'h0000_7F00;
        5: ra = 32'h0000_7F08;
        6: ra = 32'h0000_7F10;
        7: ra = 32'h0000_7F18;
        8: ra = 32'h0000_7F20;
        default: ra = {$urandom_range(0, 32'h7F), 8'h00};
      endcase
      ra = ra + 32'($urandom_range(0, 3));
      step(1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), ra, $urandom,
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m_store_buf.md
M_STORE_BUF -- requirements
Module: m_store_buf

Interface
REQ-001 The block SHALL have ports `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port `st_valid`, input, 1 bit: the M-stage instruction is presenting a store this cycle.
REQ-004 The block SHALL have port `M_sel_st`, input, 2 bits: 00 sw, 01 sh, 10 sb, 11 no store.
REQ-005 The block SHALL have port `addr`, input, 32 bits: byte address of the store.
REQ-006 The block SHALL have port `wdata`, input, 32 bits: store source value (rt).
REQ-007 The block SHALL have port `Ov`, input, 1 bit: overflow in the address arithmetic.
REQ-008 The block SHALL have port `flush`, input, 1 bit: exception/eret flush of the M stage.
REQ-009 The block SHALL have port `bus_ready`, input, 1 bit: the memory/bridge accepts the head entry.
REQ-010 The block SHALL have port `AdES`, output, 1 bit: store address exception (combinational).
REQ-011 The block SHALL have port `stall`, output, 1 bit: freeze M and earlier stages.
REQ-012 The block SHALL have port `bus_valid`, output, 1 bit: head entry valid.
REQ-013 The block SHALL have port `bus_addr`, output, 32 bits: word-aligned address, with [1:0]=00.
REQ-014 The block SHALL have port `bus_byteen`, output, 4 bits: byte write enables.
REQ-015 The block SHALL have port `bus_wdata`, output, 32 bits: lane-replicated write data.
REQ-016 The block SHALL have port `buf_empty`, output, 1 bit: no pending stores.

Function
REQ-017 A request SHALL be a store when st_valid=1 and M_sel_st≠11; all other requests are ignored.
REQ-018 Legal address ranges SHALL be: DM 0x0000–0x2FFF; TC0 0x7F00–0x7F0B; TC1 0x7F10–0x7F1B; 0x7F20–0x7F23.
REQ-019 AdES SHALL be 1 for a store when any of the following holds; otherwise AdES SHALL be 0:
- Ov=1;
- address outside the legal ranges;
- sw with addr[1:0]≠00;
- sh with addr[0]=1;
- sh or sb to a TC0 or TC1 range;
- any store to a timer count register, 0x7F08–0x7F0B or 0x7F18–0x7F1B.
REQ-020 Byte enables SHALL be:
- sw: 1111;
- sh: 0011 if addr[1]=0, 1100 if addr[1]=1;
- sb: 0001 shifted left by addr[1:0].
REQ-021 Data SHALL be:
- sw: wdata;
- sh: {2{wdata[15:0]}};
- sb: {4{wdata[7:0]}}.
REQ-022 Storage SHALL be a 2-entry FIFO of {word address, byteen, data} with an occupancy count of 0..2.
REQ-023 Push SHALL occur when the request is a store, AdES=0, flush=0, and either count<2 or a pop occurs in the same cycle.
REQ-024 Pop SHALL occur when bus_valid=1 and bus_ready=1.
REQ-025 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-026 bus_valid SHALL equal (count≠0), and bus_* SHALL present the head entry.
REQ-027 The head entry SHALL stay stable while bus_valid=1 and bus_ready=0.
REQ-028 Minimum latency SHALL be one cycle: a store pushed at edge N appears on bus_* in the cycle after edge N, never combinationally.
REQ-029 stall SHALL be 1 exactly when the request is a store, AdES=0, flush=0, count=2, and no pop occurs this cycle; the pipeline re-presents the same store next cycle.
REQ-030 A store with AdES=1 or flush=1 SHALL never be pushed; entries already buffered are committed and SHALL drain regardless of flush.
REQ-031 buf_empty SHALL equal (count=0).
REQ-032 Read and write pointers SHALL be 1 bit and wrap modulo 2.

Reset
REQ-033 When reset=0, count, pointers and all entries SHALL clear asynchronously.
REQ-034 During reset: bus_valid=0, bus_addr=0, bus_byteen=0, bus_wdata=0, stall=0, buf_empty=1; AdES follows its combinational inputs.
REQ-035 A reset asserted mid-drain SHALL discard pending entries without issuing a further bus_valid.

Verification
REQ-036 The bench SHALL cover: sb with addr=0x0000_1003, wdata=0x0000_00A5, bus_ready=1 → next cycle bus_addr=0x1000, byteen=1000, wdata=0xA5A5A5A5, then buf_empty=1.
REQ-037 The bench SHALL cover: sh to 0x0000_0001; sw to 0x7F08; sb to 0x7F04; sw to 0x3000 → each gives AdES=1, with no push and no bus_valid.
REQ-038 The bench SHALL cover: bus_ready=0 with three back-to-back sw to 0x0, 0x4, 0x8 → count reaches 2 and stall=1 on the third. Raising bus_ready → the pop and push happen in the same cycle, and bus order is 0x0, 0x4, 0x8.
REQ-039 The bench SHALL cover: flush=1 together with sw to 0x10 while one entry is pending → that entry is still issued and 0x10 is never issued.
REQ-040 The bench SHALL cover: reset=0 asynchronously while 2 entries are pending and bus_ready=0 → bus_valid falls before the next edge, and nothing is issued after reset releases.
REQ-041 The bench SHALL cover: sw with Ov=1 to 0x0000_0000 → AdES=1 and no push.
